// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: 3-stage post-add normaliser (negate, leading-zero count, shift/exponent adjust) with full-stall handshake
module fp_normalize_pipe #(
  parameter int SIG_W  = 25,
  parameter int EXP_W  = 8,
  parameter bit NEG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_uflow,
  output logic             out_oflow
);
  localparam int LZ_W = $clog2(SIG_W + 1);
  localparam int XW   = EXP_W + 2;
  logic             w_adv, w_neg, w_zero, w_uf, w_of;
  logic [SIG_W-1:0] w_mag, w_sig;
  logic [EXP_W-1:0] w_exp;
  logic [LZ_W-1:0]  w_lz, w_shift;
  logic [EXP_W:0]   w_inc;
  logic [XW-1:0]    w_dec;
  logic             r1_v, r1_sign, r1_zero;
  logic [SIG_W-1:0] r1_mag;
  logic [EXP_W-1:0] r1_exp;
  logic             r2_v, r2_sign, r2_zero;
  logic [SIG_W-1:0] r2_mag;
  logic [EXP_W-1:0] r2_exp;
  logic [LZ_W-1:0]  r2_lz;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_neg    = NEG_EN && in_neg;
  assign w_mag    = w_neg ? -in_sig : in_sig;
  assign w_zero   = w_mag == '0;
  // highest set bit wins; an all-zero magnitude leaves the count at SIG_W
  always_comb begin
    w_lz = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) if (r1_mag[i]) w_lz = LZ_W'(SIG_W - 1 - i);
  end
  assign w_shift = r2_lz - 1'b1;
  assign w_inc   = {1'b0, r2_exp} + 1'b1;
  assign w_dec   = {2'b00, r2_exp} - XW'(w_shift);
  always_comb begin
    w_of  = 1'b0;
    w_uf  = 1'b0;
    w_sig = '0;
    w_exp = '0;
    if (!r2_zero && r2_lz == '0) begin
      w_of  = w_inc >= {1'b0, {EXP_W{1'b1}}};
      w_sig = w_of ? '0 : r2_mag >> 1;
      w_exp = w_of ? '1 : w_inc[EXP_W-1:0];
    end else if (!r2_zero) begin
      w_uf  = w_dec[XW-1] || w_dec == '0;
      w_sig = w_uf ? '0 : r2_mag << w_shift;
      w_exp = w_uf ? '0 : w_dec[EXP_W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v      <= 1'b0;
      r1_sign   <= 1'b0;
      r1_zero   <= 1'b0;
      r1_mag    <= '0;
      r1_exp    <= '0;
      r2_v      <= 1'b0;
      r2_sign   <= 1'b0;
      r2_zero   <= 1'b0;
      r2_mag    <= '0;
      r2_exp    <= '0;
      r2_lz     <= '0;
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
      out_oflow <= 1'b0;
    end else if (w_adv) begin
      r1_v      <= in_valid;
      r1_sign   <= w_neg && !w_zero;
      r1_zero   <= w_zero;
      r1_mag    <= w_mag;
      r1_exp    <= in_exp;
      r2_v      <= r1_v;
      r2_sign   <= r1_sign;
      r2_zero   <= r1_zero;
      r2_mag    <= r1_mag;
      r2_exp    <= r1_exp;
      r2_lz     <= w_lz;
      out_valid <= r2_v;
      out_sig   <= w_sig;
      out_exp   <= w_exp;
      out_sign  <= r2_sign;
      out_zero  <= r2_zero;
      out_uflow <= w_uf;
      out_oflow <= w_of;
    end
  end
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb_fp_normalize_pipe: randomized scoreboard bench for fp_normalize_pipe against an arithmetic reference model
module tb_fp_normalize_pipe;
  localparam int SW = 25;
  localparam int EW = 8;
  typedef struct packed {
    logic [SW-1:0] sig;
    logic [EW-1:0] exp;
    logic          sign, zero, uf, of;
  } res_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_neg = 0;
  logic [SW-1:0] in_sig = '0;
  logic [EW-1:0] in_exp = '0;
  logic out_valid, out_ready = 1;
  logic [SW-1:0] out_sig;
  logic [EW-1:0] out_exp;
  logic out_sign, out_zero, out_uflow, out_oflow;
  int errors = 0, checks = 0;
  res_t q[$];
  res_t prev_out;
  logic stall_prev = 0, rnd_on = 0;
  fp_normalize_pipe #(.SIG_W(SW), .EXP_W(EW), .NEG_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_exp(in_exp), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
    .out_sign(out_sign), .out_zero(out_zero), .out_uflow(out_uflow), .out_oflow(out_oflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  // value-level model: magnitude, position of its top bit, then exponent arithmetic in plain integers
  function automatic res_t model(input logic [SW-1:0] s, input logic [EW-1:0] e, input logic n);
    res_t r = '0;
    longint full = longint'(1) << SW;
    longint m = n ? (full - longint'(s)) % full : longint'(s);
    int p = 0, ne;
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    while ((m >> (p + 1)) != 0) p++;
    r.sign = n;
    if (p == SW - 1) begin
      ne = int'(e) + 1;
      if (ne >= (1 << EW) - 1) begin
        r.of = 1'b1;
        r.exp = '1;
      end else begin
        r.sig = SW'(m / 2);
        r.exp = EW'(ne);
      end
    end else begin
      ne = int'(e) - (SW - 2 - p);
      if (ne < 1) r.uf = 1'b1;
      else begin
        r.sig = SW'(m << (SW - 2 - p));
        r.exp = EW'(ne);
      end
    end
    return r;
  endfunction
  always @(negedge clk) begin
    res_t got, want;
    got = {out_sig, out_exp, out_sign, out_zero, out_uflow, out_oflow};
    if (stall_prev) check("stall_stable", 64'(got), 64'(prev_out));
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          want = q.pop_front();
          check("beat", 64'(got), 64'(want));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_sig, in_exp, in_neg));
    end
    stall_prev = out_valid && !out_ready && !rst;
    prev_out = got;
  end
  always @(posedge clk) if (rnd_on) begin
    #1;
    out_ready = $urandom_range(0, 9) < 7;
  end
  task automatic send(input logic [SW-1:0] s, input logic [EW-1:0] e, input logic n);
    int t = 0;
    in_valid = 1;
    in_sig = s;
    in_exp = e;
    in_neg = n;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    out_ready = 1;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [SW-1:0] s;
    logic [EW-1:0] e;
    check("m_pass", 64'(model(25'h0800000, 8'd100, 0)), 64'({25'h0800000, 8'd100, 4'b0000}));
    check("m_carry", 64'(model(25'h1800000, 8'd100, 0)), 64'({25'h0C00000, 8'd101, 4'b0000}));
    check("m_oflow", 64'(model(25'h1800000, 8'd254, 0)), 64'({25'h0, 8'd255, 4'b0001}));
    check("m_left", 64'(model(25'h0000001, 8'd100, 0)), 64'({25'h0800000, 8'd77, 4'b0000}));
    check("m_uflow", 64'(model(25'h0000001, 8'd10, 0)), 64'({25'h0, 8'd0, 4'b0010}));
    check("m_neg", 64'(model(25'h1FFFFFF, 8'd100, 1)), 64'({25'h0800000, 8'd77, 4'b1000}));
    check("m_negzero", 64'(model(25'h0, 8'd100, 1)), 64'({25'h0, 8'd0, 4'b0100}));
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 64'({out_valid, out_sig, out_exp, out_sign, out_zero, out_uflow, out_oflow}), 64'd0);
    rst = 0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    send(25'h0800000, 8'd100, 0);
    @(posedge clk);
    #1;
    check("latency_2", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_3", 64'(out_valid), 64'd1);
    send(25'h1800000, 8'd100, 0);
    send(25'h1800000, 8'd254, 0);
    send(25'h0000001, 8'd100, 0);
    send(25'h0000001, 8'd10, 0);
    send(25'h1FFFFFF, 8'd100, 1);
    send(25'h0000000, 8'd100, 1);
    send(25'h1000000, 8'd0, 1);
    send(25'h0400000, 8'd0, 0);
    drain();
    fork
      for (int i = 0; i < 5; i++) send(25'(i + 3) << 18, EW'(50 + i), i[0]);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(25'h0123456, 8'd30, 0);
    send(25'h1ABCDEF, 8'd40, 1);
    send(25'h0000F00, 8'd90, 0);
    rst = 1;
    @(posedge clk);
    #1;
    check("midreset_out", 64'({out_valid, out_sig, out_exp, out_sign, out_zero, out_uflow, out_oflow}), 64'd0);
    rst = 0;
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_idle", 64'(q.size()), 64'd0);
    rnd_on = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        case ($urandom_range(0, 4))
          0: s = SW'($urandom);
          1: s = SW'($urandom) >> $urandom_range(0, SW - 1);
          2: s = '0;
          3: s = SW'($urandom) | 25'h1000000;
          default: s = 25'h1FFFFFF ^ SW'($urandom_range(0, 3));
        endcase
        case ($urandom_range(0, 7))
          0: e = 8'd0;
          1: e = 8'd1;
          2: e = 8'd254;
          3: e = 8'd255;
          default: e = EW'($urandom);
        endcase
        send(s, e, 1'($urandom_range(0, 1)));
      end
    end
    rnd_on = 0;
    @(posedge clk);
    #1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
